// File: rtl/pcie_pio_pkg.sv
// Shared encodings for the PCIe programmed-I/O completer: request types,
// completion status codes, FSM states and the default device ID.
package pcie_pio_pkg;

    localparam logic [1:0] REQ_MRD      = 2'b00;
    localparam logic [1:0] REQ_MWR      = 2'b01;
    localparam logic [1:0] REQ_NP_OTHER = 2'b10;
    localparam logic [1:0] REQ_P_OTHER  = 2'b11;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    localparam logic [31:0] DEV_ID_DEFAULT = 32'h4C45_474F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CPL  = 1'b1
    } pio_state_e;

endpackage

// File: rtl/pcie_pio_regfile.sv
// Byte-enabled register file with a combinational read port; offset 0 reads
// back the fixed device ID and silently ignores writes.
module pcie_pio_regfile
    import pcie_pio_pkg::*;
#(
    parameter int          ADDR_W = 6,
    parameter logic [31:0] DEV_ID = DEV_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] regs [DEPTH];

    // Entry 0 is never written, so it stays at its reset value and is pruned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = (rd_addr == '0) ? DEV_ID : regs[rd_addr];

endmodule

// File: rtl/pcie_pio_completer.sv
// Endpoint PIO responder: services single-DW MRd/MWr against a small register
// file and returns completions for non-posted requests while the link is up.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | accepting requests whenever the link is up; MWr stays here
//   ST_CPL  | completion presented, held until taken or the link drops
module pcie_pio_completer
    import pcie_pio_pkg::*;
#(
    parameter int          ADDR_W = 6,
    parameter logic [31:0] DEV_ID = DEV_ID_DEFAULT
) (
    input  logic              user_clk,
    input  logic              sys_rst_n,
    input  logic              user_lnk_up,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_data,
    input  logic [7:0]        req_tag,
    input  logic [15:0]       req_rid,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [31:0]       cpl_data,
    output logic [7:0]        cpl_tag,
    output logic [15:0]       cpl_rid,
    output logic [2:0]        cpl_status,
    output logic [15:0]       wr_count
);

    pio_state_e  state;
    pio_state_e  state_nxt;
    logic        idle_q;
    logic        accept;
    logic        is_mrd;
    logic        is_mwr;
    logic        is_np_other;
    logic [31:0] rd_data;

    // idle_q is low during reset so req_ready stays 0 regardless of the link.
    assign req_ready   = idle_q & user_lnk_up;
    assign cpl_valid   = (state == ST_CPL);
    assign accept      = req_valid & req_ready;
    assign is_mrd      = (req_type == REQ_MRD);
    assign is_mwr      = (req_type == REQ_MWR);
    assign is_np_other = (req_type == REQ_NP_OTHER);

    pcie_pio_regfile #(
        .ADDR_W (ADDR_W),
        .DEV_ID (DEV_ID)
    ) u_regfile (
        .clk     (user_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (accept & is_mwr),
        .wr_addr (req_addr),
        .wr_be   (req_be),
        .wr_data (req_data),
        .rd_addr (req_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            idle_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idle_q <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && (is_mrd || is_np_other)) begin
                    state_nxt = ST_CPL;
                end
            end
            ST_CPL: begin
                // A handshake coinciding with a link drop still counts as done.
                if ((cpl_valid && cpl_ready) || !user_lnk_up) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cpl_data   <= '0;
            cpl_tag    <= '0;
            cpl_rid    <= '0;
            cpl_status <= '0;
        end else if (accept && is_mrd) begin
            cpl_data   <= rd_data;
            cpl_tag    <= req_tag;
            cpl_rid    <= req_rid;
            cpl_status <= CPL_SC;
        end else if (accept && is_np_other) begin
            cpl_data   <= '0;
            cpl_tag    <= req_tag;
            cpl_rid    <= req_rid;
            cpl_status <= CPL_UR;
        end
    end

    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_count <= '0;
        end else if (accept && is_mwr && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pcie_pio_completer.sv
// Directed plus randomized checks of pcie_pio_completer against a
// transaction-level model of the register file and write counter.
module tb_pcie_pio_completer;

    localparam logic [31:0] DEV = 32'h4C45_474F;

    logic        user_clk;
    logic        sys_rst_n;
    logic        user_lnk_up;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [5:0]  req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic [15:0] req_rid;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [31:0] cpl_data;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_rid;
    logic [2:0]  cpl_status;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [64];
    int          mcount;

    pcie_pio_completer dut (
        .user_clk    (user_clk),
        .sys_rst_n   (sys_rst_n),
        .user_lnk_up (user_lnk_up),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .req_be      (req_be),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .req_rid     (req_rid),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_data    (cpl_data),
        .cpl_tag     (cpl_tag),
        .cpl_rid     (cpl_rid),
        .cpl_status  (cpl_status),
        .wr_count    (wr_count)
    );

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 32'h0;
        mcount = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        return (a == 6'd0) ? DEV : mregs[a];
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (a != 6'd0) mregs[a] = (mregs[a] & ~mask) | (d & mask);
        if (mcount < 65535) mcount++;
    endtask

    // Presents one request at a negedge and returns at the negedge after it is accepted.
    task automatic send(input logic [1:0] t, input logic [5:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic [7:0] tag, input logic [15:0] rid);
        int n;
        req_type  = t;
        req_addr  = a;
        req_be    = be;
        req_data  = d;
        req_tag   = tag;
        req_rid   = rid;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge user_clk);
            n++;
        end
        chk("accept_within_bound", 32'(n < 50), 32'd1);
        @(negedge user_clk);
        req_valid = 1'b0;
    endtask

    task automatic take_cpl(input logic [31:0] d, input logic [7:0] tag, input logic [15:0] rid,
                            input logic [2:0] st, input int delay);
        chk("cpl_valid_latency", 32'(cpl_valid), 32'd1);
        chk("cpl_data", cpl_data, d);
        chk("cpl_tag", 32'(cpl_tag), 32'(tag));
        chk("cpl_rid", 32'(cpl_rid), 32'(rid));
        chk("cpl_status", 32'(cpl_status), 32'(st));
        chk("req_ready_in_cpl", 32'(req_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge user_clk);
            chk("cpl_hold_valid", 32'(cpl_valid), 32'd1);
            chk("cpl_hold_data", cpl_data, d);
            chk("cpl_hold_tag", 32'(cpl_tag), 32'(tag));
            chk("req_ready_stall", 32'(req_ready), 32'd0);
        end
        cpl_ready = 1'b1;
        @(negedge user_clk);
        cpl_ready = 1'b0;
        chk("cpl_valid_after_hs", 32'(cpl_valid), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  t;
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [7:0]  tag;
        logic [15:0] rid;
        int          n1;

        sys_rst_n   = 1'b1;
        user_lnk_up = 1'b1;
        req_valid   = 1'b0;
        req_type    = 2'b00;
        req_addr    = '0;
        req_be      = '0;
        req_data    = '0;
        req_tag     = '0;
        req_rid     = '0;
        cpl_ready   = 1'b0;
        model_reset();

        // Reset state, with the link already up.
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        chk("rst_cpl_data", cpl_data, 32'd0);
        chk("rst_cpl_status", 32'(cpl_status), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        repeat (3) @(negedge user_clk);
        sys_rst_n = 1'b1;
        @(negedge user_clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Device ID read.
        send(2'b00, 6'd0, 4'hF, 32'h0, 8'h11, 16'h0100);
        take_cpl(DEV, 8'h11, 16'h0100, 3'b000, 0);

        // Partial write then read on the very next cycle.
        send(2'b01, 6'd5, 4'b0101, 32'hDEAD_BEEF, 8'h01, 16'h0100);
        model_write(6'd5, 4'b0101, 32'hDEAD_BEEF);
        chk("mwr_no_cpl", 32'(cpl_valid), 32'd0);
        send(2'b00, 6'd5, 4'b0001, 32'h0, 8'h02, 16'h0100);
        take_cpl(32'h00AD_00EF, 8'h02, 16'h0100, 3'b000, 0);
        chk("wr_count_one", 32'(wr_count), 32'd1);

        // Write to offset 0 is ignored but still counted.
        send(2'b01, 6'd0, 4'hF, 32'h1234_5678, 8'h03, 16'h0100);
        model_write(6'd0, 4'hF, 32'h1234_5678);
        send(2'b00, 6'd0, 4'hF, 32'h0, 8'h04, 16'h0100);
        take_cpl(DEV, 8'h04, 16'h0100, 3'b000, 0);
        chk("wr_count_two", 32'(wr_count), 32'(mcount));

        // Other non-posted gets UR; other posted is dropped.
        send(2'b10, 6'd5, 4'hF, 32'hFFFF_FFFF, 8'h22, 16'h0200);
        take_cpl(32'h0, 8'h22, 16'h0200, 3'b001, 0);
        send(2'b11, 6'd5, 4'hF, 32'hFFFF_FFFF, 8'h23, 16'h0200);
        chk("p_other_no_cpl", 32'(cpl_valid), 32'd0);
        chk("p_other_wr_count", 32'(wr_count), 32'(mcount));
        chk("p_other_ready", 32'(req_ready), 32'd1);

        // Backpressure for 10 cycles.
        send(2'b00, 6'd5, 4'hF, 32'h0, 8'h33, 16'h0300);
        take_cpl(model_read(6'd5), 8'h33, 16'h0300, 3'b000, 10);

        // Link drop while a completion is pending.
        send(2'b00, 6'd5, 4'hF, 32'h0, 8'h44, 16'h0400);
        chk("pre_drop_valid", 32'(cpl_valid), 32'd1);
        user_lnk_up = 1'b0;
        @(negedge user_clk);
        chk("drop_cpl_valid", 32'(cpl_valid), 32'd0);
        req_type  = 2'b01;
        req_addr  = 6'd5;
        req_be    = 4'hF;
        req_data  = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge user_clk);
            chk("lnk_down_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        chk("lnk_down_wr_count", 32'(wr_count), 32'(mcount));
        user_lnk_up = 1'b1;
        @(negedge user_clk);
        chk("lnk_up_req_ready", 32'(req_ready), 32'd1);
        send(2'b00, 6'd5, 4'hF, 32'h0, 8'h45, 16'h0400);
        take_cpl(model_read(6'd5), 8'h45, 16'h0400, 3'b000, 0);

        // Randomized mix against the model.
        for (int k = 0; k < 300; k++) begin
            t   = 2'($urandom_range(0, 3));
            a   = 6'($urandom_range(0, 63));
            be  = 4'($urandom);
            d   = $urandom;
            tag = 8'($urandom);
            rid = 16'($urandom);
            send(t, a, be, d, tag, rid);
            case (t)
                2'b00: take_cpl(model_read(a), tag, rid, 3'b000, int'($urandom_range(0, 3)));
                2'b01: begin
                    model_write(a, be, d);
                    chk("rand_mwr_no_cpl", 32'(cpl_valid), 32'd0);
                end
                2'b10: take_cpl(32'h0, tag, rid, 3'b001, int'($urandom_range(0, 3)));
                default: chk("rand_p_no_cpl", 32'(cpl_valid), 32'd0);
            endcase
        end
        chk("rand_wr_count", 32'(wr_count), 32'(mcount));

        // Back-to-back 70000 writes: one per cycle, counter saturates.
        req_type  = 2'b01;
        req_addr  = 6'd9;
        req_be    = 4'hF;
        req_data  = 32'hA5A5_0F0F;
        req_valid = 1'b1;
        n1 = 65534 - mcount;
        repeat (n1) @(negedge user_clk);
        for (int i = 0; i < n1; i++) model_write(6'd9, 4'hF, 32'hA5A5_0F0F);
        chk("wr_count_below_sat", 32'(wr_count), 32'd65534);
        repeat (70000 - n1) @(negedge user_clk);
        for (int i = 0; i < 70000 - n1; i++) model_write(6'd9, 4'hF, 32'hA5A5_0F0F);
        req_valid = 1'b0;
        chk("wr_count_sat", 32'(wr_count), 32'(mcount));
        chk("wr_count_sat_val", 32'(wr_count), 32'h0000_FFFF);
        chk("ready_during_mwr_burst", 32'(req_ready), 32'd1);
        send(2'b00, 6'd9, 4'hF, 32'h0, 8'h55, 16'h0500);
        take_cpl(model_read(6'd9), 8'h55, 16'h0500, 3'b000, 0);

        // Reset mid-completion clears everything at once.
        send(2'b00, 6'd9, 4'hF, 32'h0, 8'h66, 16'h0600);
        #2 sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_cpl_valid", 32'(cpl_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_cpl_data", cpl_data, 32'd0);
        chk("midrst_cpl_tag", 32'(cpl_tag), 32'd0);
        chk("midrst_cpl_rid", 32'(cpl_rid), 32'd0);
        chk("midrst_cpl_status", 32'(cpl_status), 32'd0);
        chk("midrst_wr_count", 32'(wr_count), 32'd0);
        @(negedge user_clk);
        sys_rst_n = 1'b1;
        @(negedge user_clk);
        send(2'b00, 6'd9, 4'hF, 32'h0, 8'h77, 16'h0700);
        take_cpl(model_read(6'd9), 8'h77, 16'h0700, 3'b000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
